fib_reg_sequencer: RTL and testbench
====================================

# fib_reg_sequencer

Initiator-side controller for the 3-port register file (two combinational read ports, one synchronous write port). On a start pulse it walks destinations FIRST_DST..LAST_DST and writes reg[d] = reg[d-2] + reg[d-1], producing the Fibonacci table seeded by reg[0] = reg[1] = 1. It drives the file's read and write address ports and consumes its read data. It is the datapath exerciser for the lab2 register-file top level.

## Interface
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- FIRST_DST, 2: first destination index; must be ≥ 2.
- LAST_DST, 31: last destination index; must be ≥ FIRST_DST and ≤ 2^ADDR_W-1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse in state DONE.
- r1_addr  out  ADDR_W  read address for operand A, reg[d-2].
- r2_addr  out  ADDR_W  read address for operand B, reg[d-1].
- r1_dout  in  DATA_W  operand A data (combinational from the register file).
- r2_dout  in  DATA_W  operand B data.
- r3_addr  out  ADDR_W  write address; must be 0 whenever r3_wr is low.
- r3_din  out  DATA_W  write data.
- r3_wr  out  1  write strobe.
- result  out  DATA_W  last value written.
- ovf  out  1  sticky; a carry out of the add occurred during the current run.

## Operation
- States: IDLE, RD, WR, DONE. Encoding is defined in the package.
- IDLE: all outputs are 0 except result and ovf, which hold. If start=1, go to RD, set dst=FIRST_DST and clear ovf.
- RD: drive r1_addr=dst-2 and r2_addr=dst-1. Register sum_q = r1_dout + r2_dout, truncated to DATA_W. Set ovf if a carry out occurs. Go to WR.
- WR: drive r3_addr=dst, r3_din=sum_q and r3_wr=1. At the edge that leaves WR:
  - result is loaded from sum_q.
  - If dst==LAST_DST, go to DONE.
  - Otherwise increment dst and go to RD.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- The register file treats any nonzero write address as a write. Therefore r3_addr is forced to 0 in every state except WR.
- start is ignored while busy; it is not queued.
- Reset values: state IDLE, dst=FIRST_DST, sum_q=0, result=0, ovf=0, and every output 0.
- Reset mid-run: the run aborts immediately. No partial write is issued after rst_n rises.

## Timing
- Each element takes 2 cycles (RD then WR). The write commits at the WR→next edge.
- The write at that edge is visible to the next RD through the file's combinational read. No forwarding path is needed.
- Edge numbering: start is high at edge 0, so RD is active in cycle 1.
  - Element k (dst=FIRST_DST+k) is written at edge 2+2k.
  - Default parameters: 30 elements, last write at edge 60, done high in cycle 61, busy low from cycle 62.
- busy rises in cycle 1.
- The earliest new start is accepted at the edge ending cycle 62.

## Configuration
- FIB_SEQ_SAT_EN defined: the adder saturates. On carry out, sum_q = all-ones, and ovf still sets.
- FIB_SEQ_SAT_EN undefined: the adder wraps modulo 2^DATA_W, and ovf still sets.

## Structure
- Package fib_seq_pkg:
  - State typedef and encodings for IDLE, RD, WR and DONE.
  - Default ADDR_W, DATA_W, FIRST_DST and LAST_DST constants.
- Sub-module fib_seq_add: DATA_W adder with carry output. It applies saturation or wrap under FIB_SEQ_SAT_EN.
- The FSM, dst counter and output registers live in fib_reg_sequencer.

## Test plan
- Bench models the register file with reg[0]=reg[1]=1, others 0, then pulses start. Required response:
  - reg[2]=2, reg[3]=3, reg[10]=89, reg[31]=2178309.
  - result=2178309, ovf=0.
  - done pulses in cycle 61.
- Monitor r3_addr every cycle of a full run. It must be nonzero only when r3_wr=1. Exactly 30 writes occur, to addresses 2..31 in order.
- Pulse start again at cycles 5 and 30 of a run. There must be no restart and no extra writes. A start pulsed in the cycle after done begins a new run.
- Deassert rst_n at cycle 17. All outputs must go to 0 asynchronously. After release, no write occurs until a new start.
- Preload reg[0]=0xFFFFFFFF and reg[1]=1. Required response:
  - Without FIB_SEQ_SAT_EN: reg[2]=0x00000000 and ovf=1.
  - With FIB_SEQ_SAT_EN: reg[2]=0xFFFFFFFF and ovf=1.
- Build with FIRST_DST=2, LAST_DST=2 and pulse start. There must be one write of 2 to reg[2], and done in cycle 3.

Source files
------------

// File: rtl/fib_seq_pkg.sv
// Shared types and default sizing for the Fibonacci register-file sequencer.
package fib_seq_pkg;

    localparam int FIB_ADDR_W    = 5;
    localparam int FIB_DATA_W    = 32;
    localparam int FIB_FIRST_DST = 2;
    localparam int FIB_LAST_DST  = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } fib_state_t;

endpackage

// File: rtl/fib_seq_add.sv
// Operand adder with carry out; FIB_SEQ_SAT_EN selects saturating instead of wrapping sums.
module fib_seq_add
    import fib_seq_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    logic [DATA_W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign carry    = full_sum[DATA_W];

`ifdef FIB_SEQ_SAT_EN
    assign sum = carry ? {DATA_W{1'b1}} : full_sum[DATA_W-1:0];
`else
    assign sum = full_sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/fib_reg_sequencer.sv
// Walks destinations FIRST_DST..LAST_DST writing reg[d] = reg[d-2] + reg[d-1] through a 3-port file.
// Saturating arithmetic is selected by defining FIB_SEQ_SAT_EN (see fib_seq_add).
module fib_reg_sequencer
    import fib_seq_pkg::*;
#(
    parameter int ADDR_W    = FIB_ADDR_W,
    parameter int DATA_W    = FIB_DATA_W,
    parameter int FIRST_DST = FIB_FIRST_DST,
    parameter int LAST_DST  = FIB_LAST_DST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] r1_addr,
    output logic [ADDR_W-1:0] r2_addr,
    input  logic [DATA_W-1:0] r1_dout,
    input  logic [DATA_W-1:0] r2_dout,
    output logic [ADDR_W-1:0] r3_addr,
    output logic [DATA_W-1:0] r3_din,
    output logic              r3_wr,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    fib_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] dst_reg;
    logic [DATA_W-1:0] sum_reg;
    logic [DATA_W-1:0] result_reg;
    logic              ovf_reg;

    logic [DATA_W-1:0] add_sum;
    logic              add_carry;
    logic              at_last;

    assign at_last = (dst_reg == ADDR_W'(LAST_DST));

    fib_seq_add #(
        .DATA_W (DATA_W)
    ) u_add (
        .a     (r1_dout),
        .b     (r2_dout),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RD;
            ST_RD:   state_next = ST_WR;
            ST_WR:   state_next = at_last ? ST_DONE : ST_RD;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operands are sampled at the end of RD; the write of the previous element
    // has already landed in the file, so no forwarding is required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_reg    <= ADDR_W'(FIRST_DST);
            sum_reg    <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        dst_reg <= ADDR_W'(FIRST_DST);
                        ovf_reg <= 1'b0;
                    end
                end
                ST_RD: begin
                    sum_reg <= add_sum;
                    if (add_carry) ovf_reg <= 1'b1;
                end
                ST_WR: begin
                    result_reg <= sum_reg;
                    if (!at_last) dst_reg <= dst_reg + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // The file writes on any nonzero address, so r3_addr stays 0 outside WR.
    always_comb begin
        busy    = (state_reg != ST_IDLE);
        done    = 1'b0;
        r1_addr = '0;
        r2_addr = '0;
        r3_addr = '0;
        r3_din  = '0;
        r3_wr   = 1'b0;
        case (state_reg)
            ST_RD: begin
                r1_addr = dst_reg - ADDR_W'(2);
                r2_addr = dst_reg - ADDR_W'(1);
            end
            ST_WR: begin
                r3_addr = dst_reg;
                r3_din  = sum_reg;
                r3_wr   = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign result = result_reg;
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_fib_reg_sequencer.sv
// Directed bench: models the 3-port register file and checks the Fibonacci walk, timing and reset behaviour.
module tb_fib_reg_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy, done;
    logic [4:0]  r1_addr, r2_addr, r3_addr;
    logic [31:0] r1_dout, r2_dout, r3_din, result;
    logic        r3_wr, ovf;

    logic        start2;
    logic        busy2, done2;
    logic [4:0]  r1_addr2, r2_addr2, r3_addr2;
    logic [31:0] r1_dout2, r2_dout2, r3_din2, result2;
    logic        r3_wr2, ovf2;

    logic [31:0] rf  [32];
    logic [31:0] rf2 [32];

    int          n_assert;
    int          n_fail;
    int          cyc;
    int          done_cyc;
    int          done_cnt;
    int          done2_cyc;
    int          wr2_cnt;
    int          bad_addr;
    int          order_err;
    logic [4:0]  wr_log [$];

`ifdef FIB_SEQ_SAT_EN
    localparam logic [31:0] OVF_REG2   = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_RESULT = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_REG2   = 32'h0000_0000;
    localparam logic [31:0] OVF_RESULT = 32'd514229;
`endif

    assign r1_dout  = rf[r1_addr];
    assign r2_dout  = rf[r2_addr];
    assign r1_dout2 = rf2[r1_addr2];
    assign r2_dout2 = rf2[r2_addr2];

    fib_reg_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .r1_addr (r1_addr),
        .r2_addr (r2_addr),
        .r1_dout (r1_dout),
        .r2_dout (r2_dout),
        .r3_addr (r3_addr),
        .r3_din  (r3_din),
        .r3_wr   (r3_wr),
        .result  (result),
        .ovf     (ovf)
    );

    fib_reg_sequencer #(
        .FIRST_DST (2),
        .LAST_DST  (2)
    ) dut_one (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start2),
        .busy    (busy2),
        .done    (done2),
        .r1_addr (r1_addr2),
        .r2_addr (r2_addr2),
        .r1_dout (r1_dout2),
        .r2_dout (r2_dout2),
        .r3_addr (r3_addr2),
        .r3_din  (r3_din2),
        .r3_wr   (r3_wr2),
        .result  (result2),
        .ovf     (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: sample outputs at the falling edge, then commit file writes just after the rising edge.
    task automatic tick();
        logic [4:0]  wa, wa2;
        logic [31:0] wd, wd2;
        @(negedge clk);
        wa  = r3_addr;
        wd  = r3_din;
        wa2 = r3_addr2;
        wd2 = r3_din2;
        if (r3_wr) wr_log.push_back(r3_addr);
        if (r3_addr != 5'd0 && !r3_wr) bad_addr++;
        if (done) begin
            done_cyc = cyc;
            done_cnt++;
        end
        if (r3_wr2) wr2_cnt++;
        if (done2) done2_cyc = cyc;
        @(posedge clk);
        #1;
        if (wa != 5'd0) rf[wa] = wd;
        if (wa2 != 5'd0) rf2[wa2] = wd2;
        cyc++;
    endtask

    task automatic seed(input logic [31:0] a0, input logic [31:0] a1);
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[0] = a0;
        rf[1] = a1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        bad_addr = 0;
        done_cnt = 0;
        done_cyc = -1;
        cyc      = 0;
    endtask

    task automatic run_until(input int last_cyc);
        while (cyc <= last_cyc) tick();
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        start2    = 1'b0;
        done2_cyc = -1;
        wr2_cnt   = 0;
        seed(32'd1, 32'd1);
        for (int i = 0; i < 32; i++) rf2[i] = 32'd0;
        rf2[0] = 32'd1;
        rf2[1] = 32'd1;
        clear_logs();

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_r1", r1_addr, 0);
        chk("rst_r3addr", r3_addr, 0);
        chk("rst_r3wr", r3_wr, 0);
        chk("rst_r3din", r3_din, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        // Full run with ignored start pulses in cycles 5 and 30
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_busy", busy, 1);
        chk("c1_r1", r1_addr, 0);
        chk("c1_r2", r2_addr, 1);
        while (cyc <= 61) begin
            start = (cyc == 5 || cyc == 30);
            tick();
        end
        start = 1'b0;
        chk("c62_busy", busy, 0);
        chk("done_cycle", done_cyc, 61);
        chk("done_count", done_cnt, 1);
        chk("write_count", wr_log.size(), 30);
        order_err = 0;
        for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != 5'(i + 2)) order_err++;
        chk("write_order", order_err, 0);
        chk("addr_leak", bad_addr, 0);
        chk("reg2", rf[2], 2);
        chk("reg3", rf[3], 3);
        chk("reg10", rf[10], 89);
        chk("reg31", rf[31], 2178309);
        chk("result", result, 2178309);
        chk("ovf_clean", ovf, 0);

        // Start in the cycle after done begins a new run; then reset it in cycle 17
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_r2", r2_addr, 1);
        run_until(16);
        chk("c17_r1", r1_addr, 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_r1", r1_addr, 0);
        chk("arst_r2", r2_addr, 0);
        chk("arst_r3addr", r3_addr, 0);
        chk("arst_r3din", r3_din, 0);
        chk("arst_r3wr", r3_wr, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_ovf", ovf, 0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_wr", wr_log.size(), 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_leak", bad_addr, 0);

        // Carry out of the first add
        seed(32'hFFFF_FFFF, 32'd1);
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(61);
        chk("ovf_reg2", rf[2], OVF_REG2);
        chk("ovf_flag", ovf, 1);
        chk("ovf_result", result, OVF_RESULT);

        // A clean run clears the sticky flag
        seed(32'd1, 32'd1);
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(61);
        chk("ovf_cleared", ovf, 0);
        chk("result_again", result, 2178309);

        // Single-element build
        clear_logs();
        wr2_cnt   = 0;
        done2_cyc = -1;
        start2    = 1'b1;
        tick();
        start2    = 1'b0;
        run_until(5);
        chk("one_writes", wr2_cnt, 1);
        chk("one_reg2", rf2[2], 2);
        chk("one_done_cyc", done2_cyc, 3);
        chk("one_result", result2, 2);
        chk("one_busy", busy2, 0);
        chk("one_ovf", ovf2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
